pipe_skid_buffer: RTL and testbench

Two-entry elastic pipeline register with a valid/ready handshake on both sides. It sits between adjacent pipeline stages and replaces bare enable-driven stage registers wherever a downstream stall must not ripple combinationally back upstream. It sustains one transfer per cycle and registers every output, including `in_ready`, so no combinational path runs from `out_ready` to `in_ready`.

---
 rtl/pipe_skid_buffer.sv | 88 ++++++++
 tb/tb_pipe_skid_buffer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_buffer.sv
// Two-entry elastic pipeline register: main register M drives the output, skid
// register S absorbs the one word that arrives while in_ready is still falling.
module pipe_skid_buffer #(
  parameter int unsigned           WIDTH = 32,
  parameter logic [WIDTH-1:0]      INIT  = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             in_fire;
  logic             out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  // Next state, data moves and the registered handshake outputs derived from it.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = BUSY;
          main_d  = in_data;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          state_d = FULL;
          skid_d  = in_data;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_d = BUSY;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != FULL);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      main_q      <= INIT;
      skid_q      <= INIT;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Bench for pipe_skid_buffer: directed vector table, hand-written reset/stream
// sequences and random backpressure against a two-deep FIFO reference model.
module tb_pipe_skid_buffer;

  localparam int unsigned      W      = 32;
  localparam logic [W-1:0]     INIT_V = 32'hDEADBEEF;
  localparam int               NWORDS = 1000;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  always #5 clock = ~clock;

  pipe_skid_buffer #(.WIDTH(W), .INIT(INIT_V)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a FIFO of capacity two; the output word is the FIFO head,
  // or the last word that was at the head once the FIFO has drained.
  logic [W-1:0] m_q[$];
  logic [W-1:0] m_head;
  logic         m_ir;
  int           m_sent;
  int           m_recv;

  typedef struct {
    logic         iv;
    logic [W-1:0] d;
    logic         ord;
    logic         e_ir;
    logic         e_ov;
    logic [W-1:0] e_od;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_head = INIT_V;
    m_ir   = 1'b0;
  endtask

  task automatic model_step(input logic iv, input logic [W-1:0] d, input logic ord);
    logic ifire, ofire;
    ifire = iv && m_ir;
    ofire = (m_q.size() != 0) && ord;
    if (ofire) begin
      m_head = m_q.pop_front();
      m_recv++;
    end
    if (ifire) begin
      m_q.push_back(d);
      m_sent++;
    end
    if (m_q.size() != 0) m_head = m_q[0];
    m_ir = (m_q.size() < 2);
  endtask

  // Apply inputs just after an edge, advance one edge, compare against the model.
  task automatic drive(input logic iv, input logic [W-1:0] d, input logic ord, input string tag);
    in_valid  = iv;
    in_data   = d;
    out_ready = ord;
    model_step(iv, d, ord);
    @(posedge clock);
    #1;
    chk({tag, "/in_ready"},  W'(in_ready),  W'(m_ir));
    chk({tag, "/out_valid"}, W'(out_valid), W'(m_q.size() != 0));
    chk({tag, "/out_data"},  out_data,      m_head);
  endtask

  initial begin
    // Directed table starting from EMPTY with in_ready = 1.
    tbl[0]  = '{1'b1, 32'd5,  1'b0, 1'b1, 1'b1, 32'd5};
    tbl[1]  = '{1'b1, 32'd6,  1'b0, 1'b0, 1'b1, 32'd5};
    tbl[2]  = '{1'b1, 32'd7,  1'b0, 1'b0, 1'b1, 32'd5};
    tbl[3]  = '{1'b0, 32'd0,  1'b1, 1'b1, 1'b1, 32'd6};
    tbl[4]  = '{1'b0, 32'd0,  1'b1, 1'b1, 1'b0, 32'd6};
    tbl[5]  = '{1'b0, 32'd0,  1'b1, 1'b1, 1'b0, 32'd6};
    tbl[6]  = '{1'b1, 32'h42, 1'b1, 1'b1, 1'b1, 32'h42};
    tbl[7]  = '{1'b0, 32'd0,  1'b1, 1'b1, 1'b0, 32'h42};
    tbl[8]  = '{1'b0, 32'd0,  1'b1, 1'b1, 1'b0, 32'h42};
    tbl[9]  = '{1'b1, 32'd1,  1'b1, 1'b1, 1'b1, 32'd1};
    tbl[10] = '{1'b1, 32'd2,  1'b1, 1'b1, 1'b1, 32'd2};
    tbl[11] = '{1'b1, 32'd3,  1'b0, 1'b0, 1'b1, 32'd2};
    tbl[12] = '{1'b0, 32'd0,  1'b0, 1'b0, 1'b1, 32'd2};
    tbl[13] = '{1'b1, 32'd4,  1'b1, 1'b1, 1'b1, 32'd3};
    tbl[14] = '{1'b1, 32'd4,  1'b1, 1'b1, 1'b1, 32'd4};
    tbl[15] = '{1'b0, 32'd0,  1'b0, 1'b1, 1'b1, 32'd4};

    m_sent = 0;
    m_recv = 0;
    model_reset();
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    reset     = 1'b0;

    // Asynchronous reset between clock edges takes effect immediately.
    #2 reset = 1'b1;
    #1;
    chk("rst/out_valid", W'(out_valid), W'(1'b0));
    chk("rst/in_ready",  W'(in_ready),  W'(1'b0));
    chk("rst/out_data",  out_data,      INIT_V);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    chk("rst_low/in_ready", W'(in_ready), W'(1'b0));
    // First edge with reset low cannot accept, even with in_valid high.
    drive(1'b1, 32'hBAD0_0001, 1'b1, "first_edge");
    chk("first_edge/ir_is_1", W'(in_ready), W'(1'b1));

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].iv, tbl[i].d, tbl[i].ord, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d/e_ir", i), W'(in_ready),  W'(tbl[i].e_ir));
      chk($sformatf("tbl%0d/e_ov", i), W'(out_valid), W'(tbl[i].e_ov));
      chk($sformatf("tbl%0d/e_od", i), out_data,      tbl[i].e_od);
    end

    // Streaming: 1..16 back to back, each visible one cycle after acceptance.
    drive(1'b0, '0, 1'b1, "pre_stream");
    drive(1'b0, '0, 1'b1, "pre_stream");
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, W'(i), 1'b1, $sformatf("stream%0d", i));
      chk($sformatf("stream%0d/word", i),  out_data,      W'(i));
      chk($sformatf("stream%0d/valid", i), W'(out_valid), W'(1'b1));
    end
    drive(1'b0, '0, 1'b1, "stream_end");
    chk("stream_end/valid", W'(out_valid), W'(1'b0));

    // Random backpressure with a scoreboard through the model FIFO.
    begin
      int base_sent, base_recv, cyc;
      base_sent = m_sent;
      base_recv = m_recv;
      cyc = 0;
      while (((m_sent - base_sent) < NWORDS || m_q.size() != 0) && cyc < 20000) begin
        logic iv, ord;
        iv  = ((m_sent - base_sent) < NWORDS) ? 1'($urandom_range(0, 1)) : 1'b0;
        ord = 1'($urandom_range(0, 1));
        drive(iv, W'($urandom), ord, "rand");
        cyc++;
      end
      chk("rand/sent", W'(m_sent - base_sent), W'(NWORDS));
      chk("rand/recv", W'(m_recv - base_recv), W'(NWORDS));
    end

    // Reset while FULL discards both buffered words.
    drive(1'b1, 32'd7, 1'b0, "fill7");
    drive(1'b1, 32'd8, 1'b0, "fill8");
    chk("full/in_ready", W'(in_ready), W'(1'b0));
    chk("full/out_data", out_data,     32'd7);
    #3 reset = 1'b1;
    #1;
    model_reset();
    chk("rst_full/out_valid", W'(out_valid), W'(1'b0));
    chk("rst_full/in_ready",  W'(in_ready),  W'(1'b0));
    chk("rst_full/out_data",  out_data,      INIT_V);
    @(posedge clock);
    #1 reset = 1'b0;
    drive(1'b0, '0, 1'b1, "post_rst");
    drive(1'b0, '0, 1'b1, "post_rst");
    drive(1'b1, 32'd9, 1'b1, "word9");
    chk("word9/data", out_data, 32'd9);
    drive(1'b0, '0, 1'b1, "word9_out");
    drive(1'b0, '0, 1'b1, "idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
